// File: rtl/rx_pkt_ctrl_if.sv
// ---------------------------------------------------------------------------
// rx_pkt_ctrl_if
// Bundle of the receive-packet sequencer's configuration, detector and
// payload signals.
//   master : upstream side (drives config, PD/BD flags, bits, strobes)
//   slave  : rx_pkt_ctrl (drives disassert_BD, payload, pulses, status)
// Optional statistics signals exist only when RX_PKT_STATS_EN is defined.
// ---------------------------------------------------------------------------
interface rx_pkt_ctrl_if #(
    parameter int LEN_WIDTH = 16,
    parameter int TO_WIDTH  = 16
) ();
    logic [LEN_WIDTH-1:0] PKT_LEN;
    logic [TO_WIDTH-1:0]  SEARCH_TIMEOUT;
    logic                 PD_flag;
    logic                 BD_flag;
    logic                 BD_sgn;
    logic                 bit_in;
    logic                 sym_vld;
    logic                 disassert_BD;
    logic                 data_out;
    logic                 data_vld;
    logic                 pkt_start;
    logic                 pkt_done;
    logic                 pkt_timeout;
    logic                 pkt_abort;
    logic                 busy;
    logic [1:0]           state;
`ifdef RX_PKT_STATS_EN
    logic [15:0]          good_cnt;
    logic [15:0]          to_cnt_total;
    logic [15:0]          abort_cnt;
`endif

    modport master (
        output PKT_LEN, SEARCH_TIMEOUT, PD_flag, BD_flag, BD_sgn, bit_in, sym_vld,
        input  disassert_BD, data_out, data_vld, pkt_start, pkt_done,
               pkt_timeout, pkt_abort, busy, state
`ifdef RX_PKT_STATS_EN
        , input good_cnt, to_cnt_total, abort_cnt
`endif
    );

    modport slave (
        input  PKT_LEN, SEARCH_TIMEOUT, PD_flag, BD_flag, BD_sgn, bit_in, sym_vld,
        output disassert_BD, data_out, data_vld, pkt_start, pkt_done,
               pkt_timeout, pkt_abort, busy, state
`ifdef RX_PKT_STATS_EN
        , output good_cnt, to_cnt_total, abort_cnt
`endif
    );
endinterface

// File: rtl/rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// rx_pkt_ctrl
// Receive-packet sequencer behind the BPSK bit-boundary detector. Waits for
// preamble, then for the boundary flag, removes the header sign ambiguity and
// emits PKT_LEN payload bits. At packet end (done/abort/timeout) it holds
// disassert_BD for at least GUARD_CYCLES cycles and until BD_flag drops, so
// the detector re-arms before the next packet.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : rx_pkt_ctrl_if.slave (config, PD/BD flags, bits, pulses, status)
// Optional build macro RX_PKT_STATS_EN adds saturating good/timeout/abort
// packet counters on the interface.
// ---------------------------------------------------------------------------
module rx_pkt_ctrl #(
    parameter int LEN_WIDTH    = 16,
    parameter int TO_WIDTH     = 16,
    parameter int GUARD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    rx_pkt_ctrl_if.slave bus
);
    localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0]       GUARD_MAX = GW'(GUARD_CYCLES);
    localparam logic [TO_WIDTH-1:0] TO_SAT    = {TO_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_RECV   = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [TO_WIDTH-1:0]  r_timeout;
    logic [TO_WIDTH-1:0]  r_to_cnt;
    logic [LEN_WIDTH-1:0] r_bit_cnt;
    logic [GW-1:0]        r_guard_cnt;
    logic                 r_pol;
    logic                 r_disassert;
    logic                 r_data_out;
    logic                 r_data_vld;
    logic                 r_pkt_start;
    logic                 r_pkt_done;
    logic                 r_pkt_timeout;
    logic                 r_pkt_abort;
    logic                 r_busy;

    logic [TO_WIDTH-1:0]  w_to_inc;
    logic                 w_to_hit;
    logic                 w_last_bit;
    logic                 w_guard_ok;
    logic                 w_len_zero;
    logic                 w_start;
    logic                 w_done;
    logic                 w_timeout;
    logic                 w_abort;
    logic                 w_emit;
    logic                 w_disassert_nxt;

    // Shared condition decode from latched config and counters
    always_comb begin
        w_to_inc   = r_to_cnt + TO_WIDTH'(1);
        // A nonzero timeout is hit before to_cnt can saturate, so the
        // incremented value never wraps when it matters.
        w_to_hit   = (r_timeout != {TO_WIDTH{1'b0}}) && (w_to_inc == r_timeout);
        w_last_bit = (r_bit_cnt == (r_len - LEN_WIDTH'(1)));
        w_guard_ok = (r_guard_cnt >= GUARD_MAX);
        w_len_zero = (r_len == {LEN_WIDTH{1'b0}});
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.PD_flag) w_state_nxt = ST_SEARCH;
                else             w_state_nxt = ST_IDLE;
            end
            ST_SEARCH: begin
                if (!bus.PD_flag)                  w_state_nxt = ST_IDLE;
                else if (bus.BD_flag)              w_state_nxt = w_len_zero ? ST_FLUSH : ST_RECV;
                else if (bus.sym_vld && w_to_hit)  w_state_nxt = ST_FLUSH;
                else                               w_state_nxt = ST_SEARCH;
            end
            ST_RECV: begin
                // A strobe always wins: the bit goes out even if PD drops with it.
                if (bus.sym_vld)       w_state_nxt = w_last_bit ? ST_FLUSH : ST_RECV;
                else if (!bus.PD_flag) w_state_nxt = ST_FLUSH;
                else                   w_state_nxt = ST_RECV;
            end
            ST_FLUSH: begin
                if (w_guard_ok && !bus.BD_flag) w_state_nxt = ST_IDLE;
                else                            w_state_nxt = ST_FLUSH;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered pulses and flags
    always_comb begin
        w_start   = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        w_abort   = 1'b0;
        w_emit    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                w_start   = bus.PD_flag & bus.BD_flag;
                w_done    = bus.PD_flag & bus.BD_flag & w_len_zero;
                w_timeout = bus.PD_flag & ~bus.BD_flag & bus.sym_vld & w_to_hit;
            end
            ST_RECV: begin
                w_emit  = bus.sym_vld;
                w_done  = bus.sym_vld & w_last_bit;
                w_abort = ~bus.sym_vld & ~bus.PD_flag;
            end
            default: begin
                w_emit = 1'b0;
            end
        endcase
        // Held only while remaining in FLUSH: rises one cycle after entry and
        // drops together with the return to IDLE.
        w_disassert_nxt = (r_state == ST_FLUSH) && (w_state_nxt == ST_FLUSH);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Latched config, polarity, bit/timeout counters and FLUSH guard counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= {LEN_WIDTH{1'b0}};
            r_timeout   <= {TO_WIDTH{1'b0}};
            r_to_cnt    <= {TO_WIDTH{1'b0}};
            r_bit_cnt   <= {LEN_WIDTH{1'b0}};
            r_pol       <= 1'b0;
            r_guard_cnt <= {GW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.PD_flag) begin
                        r_len     <= bus.PKT_LEN;
                        r_timeout <= bus.SEARCH_TIMEOUT;
                        r_to_cnt  <= {TO_WIDTH{1'b0}};
                    end
                end
                ST_SEARCH: begin
                    if (w_start) begin
                        r_pol     <= bus.BD_sgn;
                        r_bit_cnt <= {LEN_WIDTH{1'b0}};
                    end else if (bus.PD_flag && bus.sym_vld && (r_to_cnt != TO_SAT)) begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                ST_RECV: begin
                    // Leaves at len-1, so bit_cnt peaks at len and never wraps.
                    if (bus.sym_vld) r_bit_cnt <= r_bit_cnt + LEN_WIDTH'(1);
                end
                default: begin
                    r_bit_cnt <= r_bit_cnt;
                end
            endcase
            if (r_state != ST_FLUSH) r_guard_cnt <= {GW{1'b0}};
            else if (!w_guard_ok)    r_guard_cnt <= r_guard_cnt + GW'(1);
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disassert   <= 1'b0;
            r_data_out    <= 1'b0;
            r_data_vld    <= 1'b0;
            r_pkt_start   <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_pkt_timeout <= 1'b0;
            r_pkt_abort   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_disassert   <= w_disassert_nxt;
            r_data_vld    <= w_emit;
            r_pkt_start   <= w_start;
            r_pkt_done    <= w_done;
            r_pkt_timeout <= w_timeout;
            r_pkt_abort   <= w_abort;
            r_busy        <= (w_state_nxt != ST_IDLE);
            if (w_emit) r_data_out <= bus.bit_in ^ r_pol;
        end
    end

    assign bus.disassert_BD = r_disassert;
    assign bus.data_out     = r_data_out;
    assign bus.data_vld     = r_data_vld;
    assign bus.pkt_start    = r_pkt_start;
    assign bus.pkt_done     = r_pkt_done;
    assign bus.pkt_timeout  = r_pkt_timeout;
    assign bus.pkt_abort    = r_pkt_abort;
    assign bus.busy         = r_busy;
    assign bus.state        = r_state;

`ifdef RX_PKT_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_to_cnt_total;
    logic [15:0] r_abort_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF)) sat_inc16 = v + 16'd1;
        else                       sat_inc16 = v;
    endfunction

    // Saturating packet outcome counters, updated with their pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt     <= 16'd0;
            r_to_cnt_total <= 16'd0;
            r_abort_cnt    <= 16'd0;
        end else begin
            r_good_cnt     <= sat_inc16(r_good_cnt, w_done);
            r_to_cnt_total <= sat_inc16(r_to_cnt_total, w_timeout);
            r_abort_cnt    <= sat_inc16(r_abort_cnt, w_abort);
        end
    end

    assign bus.good_cnt     = r_good_cnt;
    assign bus.to_cnt_total = r_to_cnt_total;
    assign bus.abort_cnt    = r_abort_cnt;
`endif
endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// Self-checking bench for rx_pkt_ctrl. Expected values come from the packet
// description (payload XOR polarity, strobe counts, guard/BD-hold arithmetic).
module tb_rx_pkt_ctrl;
    localparam int LW = 8;
    localparam int TW = 8;
    localparam int G  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_good   = 0;
    int   m_to     = 0;
    int   m_abort  = 0;
    logic [255:0] pay;

    rx_pkt_ctrl_if #(.LEN_WIDTH(LW), .TO_WIDTH(TW)) ifc ();

    rx_pkt_ctrl #(.LEN_WIDTH(LW), .TO_WIDTH(TW), .GUARD_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] all_outs();
        return {ifc.disassert_BD, ifc.data_out, ifc.data_vld, ifc.pkt_start, ifc.pkt_done,
                ifc.pkt_timeout, ifc.pkt_abort, ifc.busy, ifc.state};
    endfunction

    // FLUSH: BD held for `hold` cycles; exit after max(G, hold) more cycles.
    task automatic do_flush(input int hold);
        int k, dis, pul, exp_exit;
        exp_exit = (hold + 1 > G + 1) ? hold + 1 : G + 1;
        check("flush_entry_dis_low", ifc.disassert_BD, 0);
        k = 0; dis = 0; pul = 0;
        while (k < 64) begin
            k++;
            ifc.BD_flag = (k <= hold);
            ifc.PD_flag = 1'($urandom);
            ifc.sym_vld = 1'($urandom);
            ifc.bit_in  = 1'($urandom);
            tick();
            if (ifc.state == 2'd0) break;
            dis += int'(ifc.disassert_BD);
            pul += int'(ifc.data_vld | ifc.pkt_start | ifc.pkt_done | ifc.pkt_timeout | ifc.pkt_abort);
        end
        check("flush_exit_cycle", k, exp_exit);
        check("flush_dis_cycles", dis, exp_exit - 1);
        check("flush_no_pulses", pul, 0);
        check("idle_dis_low", {ifc.disassert_BD, ifc.busy}, 0);
        ifc.PD_flag = 1'b0; ifc.BD_flag = 1'b0; ifc.sym_vld = 1'b0;
    endtask

    // One packet: abort_after<0 means none, else PD lost after that many bits.
    task automatic run_pkt(input int len, input logic pol, input logic [255:0] p,
                           input int abort_after, input int hold, input logic rnd);
        int s, sent, iter;
        ifc.PKT_LEN = LW'(len); ifc.SEARCH_TIMEOUT = '0;
        ifc.PD_flag = 1'b1; ifc.BD_flag = 1'b0; ifc.sym_vld = 1'b0;
        tick();
        check("search_entry", ifc.state, 1);
        ifc.PKT_LEN = LW'($urandom);   // must already be latched
        s = rnd ? int'($urandom_range(0, 4)) : 1;
        repeat (s) begin
            ifc.sym_vld = 1'($urandom); ifc.bit_in = 1'($urandom);
            tick();
            check("search_no_start", {ifc.pkt_start, ifc.data_vld}, 0);
        end
        ifc.BD_flag = 1'b1; ifc.BD_sgn = pol; ifc.sym_vld = 1'($urandom);
        tick();
        check("pkt_start", ifc.pkt_start, 1);
        check("start_done_len0", ifc.pkt_done, len == 0);
        check("start_no_vld", ifc.data_vld, 0);
        check("start_state", ifc.state, (len == 0) ? 3 : 2);
        if (len == 0) m_good++;
        sent = 0; iter = 0;
        while (len > 0) begin
            iter++;
            ifc.BD_flag = 1'($urandom); ifc.BD_sgn = 1'($urandom);
            if (sent == abort_after) begin
                ifc.PD_flag = 1'b0; ifc.sym_vld = 1'b0;
                tick();
                check("abort_pulse", ifc.pkt_abort, 1);
                check("abort_no_vld_done", {ifc.data_vld, ifc.pkt_done}, 0);
                check("abort_state", ifc.state, 3);
                m_abort++;
                break;
            end
            ifc.sym_vld = (rnd && iter < 4 * len + 8) ? ($urandom_range(0, 2) != 0) : 1'b1;
            ifc.PD_flag = !(abort_after > 0 && sent == abort_after - 1 && ifc.sym_vld);
            ifc.bit_in  = ifc.sym_vld ? p[sent] : 1'($urandom);
            tick();
            check("no_abort", ifc.pkt_abort, 0);
            if (ifc.sym_vld) begin
                check("data_vld", ifc.data_vld, 1);
                check("data_out", ifc.data_out, p[sent] ^ pol);
                sent++;
                check("done_on_last", ifc.pkt_done, sent == len);
                if (sent == len) begin
                    check("done_state", ifc.state, 3);
                    m_good++;
                    break;
                end
            end else begin
                check("no_vld_gap", {ifc.data_vld, ifc.pkt_done}, 0);
            end
        end
        ifc.sym_vld = 1'b0;
        do_flush(hold);
    endtask

    task automatic run_timeout(input int to, input logic rnd);
        int st, k;
        st = 0; k = 0;
        ifc.PKT_LEN = LW'($urandom); ifc.SEARCH_TIMEOUT = TW'(to);
        ifc.PD_flag = 1'b1; ifc.BD_flag = 1'b0; ifc.sym_vld = 1'b0;
        tick();
        check("to_search_entry", ifc.state, 1);
        ifc.SEARCH_TIMEOUT = TW'(to + 3);  // must already be latched
        while (k < 2000) begin
            k++;
            ifc.sym_vld = rnd ? 1'($urandom) : 1'b1;
            ifc.bit_in  = 1'($urandom);
            tick();
            check("to_no_start_data", {ifc.pkt_start, ifc.data_vld}, 0);
            if (ifc.sym_vld) st++;
            if (st == to) begin
                check("timeout_pulse", ifc.pkt_timeout, 1);
                check("timeout_state", ifc.state, 3);
                m_to++;
                break;
            end
            check("timeout_early", ifc.pkt_timeout, 0);
        end
        check("timeout_strobes", st, to);
        ifc.sym_vld = 1'b0;
        do_flush(0);
    endtask

    initial begin
        int len, ab;
        rst = 1'b1;
        ifc.PKT_LEN = '1; ifc.SEARCH_TIMEOUT = '1; ifc.PD_flag = 1'b1; ifc.BD_flag = 1'b1;
        ifc.BD_sgn = 1'b1; ifc.bit_in = 1'b1; ifc.sym_vld = 1'b1;
        tick(); tick();
        check("reset_outputs", all_outs(), 0);
        rst = 1'b0;
        ifc.PD_flag = 1'b0; ifc.BD_flag = 1'b0; ifc.BD_sgn = 1'b0;
        ifc.bit_in = 1'b0; ifc.sym_vld = 1'b0;
        tick();
        check("idle_hold", {ifc.state, ifc.busy}, 0);

        pay = 256'b01001101;                   // bits sent 1,0,1,1,0,0,1,0
        run_pkt(8, 1'b0, pay, -1, 0, 1'b0);    // nominal
        run_pkt(8, 1'b1, pay, -1, 0, 1'b0);    // inverted polarity
        run_timeout(5, 1'b0);
        for (int i = 0; i < 256; i++) pay[i] = 1'($urandom);
        run_pkt(16, 1'b0, pay, 6, 0, 1'b0);    // abort after 6 bits
        run_pkt(8, 1'b0, pay, -1, 10, 1'b0);   // BD held 10 cycles in FLUSH
        run_pkt(0, 1'b1, pay, -1, 0, 1'b0);    // zero-length packet
        run_timeout(255, 1'b0);                // largest timeout
        run_timeout(3, 1'b1);
        for (int i = 0; i < 256; i++) pay[i] = 1'($urandom);
        run_pkt(255, 1'($urandom), pay, -1, 2, 1'b1);   // max length

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 256; i++) pay[i] = 1'($urandom);
            len = int'($urandom_range(1, 40));
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_pkt(len, 1'($urandom), pay, ab, int'($urandom_range(0, 8)), 1'b1);
        end

        // Reset in the middle of a packet
        ifc.PKT_LEN = 8'd20; ifc.PD_flag = 1'b1;
        tick();
        ifc.BD_flag = 1'b1; ifc.BD_sgn = 1'b1;
        tick();
        ifc.BD_flag = 1'b0; ifc.sym_vld = 1'b1;
        repeat (3) begin ifc.bit_in = 1'($urandom); tick(); end
        check("pre_reset_recv", ifc.state, 2);
        rst = 1'b1;
        tick();
        check("rst_mid_recv", all_outs(), 0);
        m_good = 0; m_to = 0; m_abort = 0;
        rst = 1'b0; ifc.PD_flag = 1'b0; ifc.sym_vld = 1'b0;
        tick();
        check("post_reset_idle", {ifc.state, ifc.pkt_abort}, 0);
        run_pkt(3, 1'b1, pay, -1, 0, 1'b0);

`ifdef RX_PKT_STATS_EN
        check("stats_good", ifc.good_cnt, m_good);
        check("stats_timeout", ifc.to_cnt_total, m_to);
        check("stats_abort", ifc.abort_cnt, m_abort);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_pkt_ctrl.md
Name: rx_pkt_ctrl

Overview:
Receive-packet sequencer sitting after the bit-boundary (BD) detector in the BPSK Rx chain. It waits for preamble detect, then waits for the BD flag. It then strips the sign ambiguity and counts out a configured number of payload bits. When the packet ends it pulses/holds disassert_BD so the detector re-arms for the next packet; it also times out a stalled boundary search.

Parameters:
LEN_WIDTH, 16, width of payload length and bit counter
TO_WIDTH, 16, width of search-timeout counter
GUARD_CYCLES, 4, minimum cycles disassert_BD is held in FLUSH (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
PKT_LEN  in  LEN_WIDTH  payload length in bits; sampled on IDLE->SEARCH
SEARCH_TIMEOUT  in  TO_WIDTH  max sym_vld strobes in SEARCH; 0 = no timeout; sampled on IDLE->SEARCH
PD_flag  in  1  preamble detected (level)
BD_flag  in  1  boundary detected (level, from BD detector)
BD_sgn  in  1  header polarity from BD detector, valid while BD_flag=1
bit_in  in  1  hard-decision BPSK bit
sym_vld  in  1  bit_in valid strobe (one per symbol)
disassert_BD  out  1  clears/re-arms BD detector
data_out  out  1  polarity-corrected payload bit
data_vld  out  1  data_out valid, 1-cycle pulse
pkt_start  out  1  1-cycle pulse, boundary accepted
pkt_done  out  1  1-cycle pulse, last payload bit emitted
pkt_timeout  out  1  1-cycle pulse, search timed out
pkt_abort  out  1  1-cycle pulse, PD_flag lost in RECV
busy  out  1  state != IDLE
state  out  2  IDLE=0, SEARCH=1, RECV=2, FLUSH=3

Behaviour:
- Reset: state=IDLE; all outputs 0; internal counters, latched config and polarity reg 0. Reset mid-packet aborts silently; no pkt_abort pulse.
- Pulse outputs default to 0 every cycle unless set below.
- IDLE: if PD_flag=1 -> SEARCH; latch PKT_LEN and SEARCH_TIMEOUT; clear to_cnt.
- SEARCH, priority order:
  - PD_flag=0 -> IDLE.
  - Else BD_flag=1 -> latch pol=BD_sgn; pulse pkt_start; bit_cnt=0; go to RECV (or to FLUSH with pkt_done in the same cycle if latched len=0).
  - Else if sym_vld: to_cnt+1. If timeout!=0 and to_cnt+1==timeout -> pulse pkt_timeout, go to FLUSH.
- RECV:
  - On sym_vld: data_out<=bit_in^pol; data_vld<=1 (1 CC latency after sym_vld); bit_cnt+1.
  - If bit_cnt==len-1 on that strobe: pulse pkt_done in the same cycle as the final data_vld, go to FLUSH.
  - If PD_flag=0 and sym_vld=0: pulse pkt_abort, go to FLUSH.
  - PD_flag=0 with sym_vld=1 in the same cycle: the bit is still emitted, then abort.
  - BD_flag changes in RECV are ignored.
- FLUSH: disassert_BD=1 (registered, asserted the cycle after entry). Stay until guard_cnt>=GUARD_CYCLES and BD_flag=0, then disassert_BD<=0 and go to IDLE. Inputs other than BD_flag are ignored.
- Counter widths: bit_cnt LEN_WIDTH, to_cnt TO_WIDTH, guard counter saturates; no wrap.
- A packet of PKT_LEN=2^LEN_WIDTH-1 must complete without overflow.
- Back-to-back packets: a new packet is accepted only after returning to IDLE. The minimum gap is GUARD_CYCLES+2 cycles.

Optional Feature:
RX_PKT_STATS_EN:
- Defined: adds outputs good_cnt[15:0], to_cnt_total[15:0], abort_cnt[15:0]. They increment on pkt_done, pkt_timeout and pkt_abort respectively, saturate at 0xFFFF, and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Nominal: PKT_LEN=8, PD_flag=1, BD_flag rises with BD_sgn=0, 8 sym_vld with bits 10110010 -> pkt_start x1; data_out 10110010 with 8 data_vld; pkt_done on 8th; disassert_BD high >=4 cycles; return to IDLE.
- Inverted polarity: same stimulus with BD_sgn=1 -> data_out 01001101; pkt_done timing unchanged.
- Timeout: SEARCH_TIMEOUT=5, BD_flag held 0, sym_vld every cycle -> pkt_timeout on 5th strobe; FLUSH; no pkt_start, no data_vld.
- Abort: PKT_LEN=16, PD_flag drops after 6 bits -> exactly 6 data_vld, pkt_abort x1, no pkt_done, disassert_BD asserted.
- FLUSH hold: BD_flag kept 1 for 10 cycles after pkt_done with GUARD_CYCLES=4 -> disassert_BD stays 1 until BD_flag falls; IDLE the cycle after.
- Edge/reset: PKT_LEN=0 -> pkt_start and pkt_done in the same cycle, no data_vld; rst asserted mid-RECV -> all outputs 0 next cycle, state=IDLE.
